// File: rtl/shr_frame_scheduler_if.sv
// Frame scheduler bus: requester levels and config toward the scheduler, shifter handshake and status back.
// Latency: none (wires only).
// Backpressure: none; eng_start/eng_done is a start/complete pulse pair.
interface shr_frame_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             req_send;
    logic             req_clr;
    logic             clr_to_one;
    logic             auto_en;
    logic [CNT_W-1:0] auto_period;
    logic [7:0]       gap_cycles;
    logic             eng_done;
    logic             eng_start;
    logic [1:0]       frame_src;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic             overrun;
    logic             wdog_err;

    modport master (
        output req_send, req_clr, clr_to_one, auto_en, auto_period, gap_cycles, eng_done,
        input  eng_start, frame_src, busy, frame_cnt, overrun, wdog_err
    );

    modport slave (
        input  req_send, req_clr, clr_to_one, auto_en, auto_period, gap_cycles, eng_done,
        output eng_start, frame_src, busy, frame_cnt, overrun, wdog_err
    );
endinterface

// File: rtl/shr_frame_scheduler.sv
// Arbitrates clear/send/auto frame requests onto the shifter; optional SHR_WDOG_EN adds a WAIT watchdog.
// Latency: pending request to eng_start 1 cycle from IDLE; req_* level edges add SYNC_STAGES+1 cycles.
// Backpressure: one frame in flight; later requests stay pending, a repeat while pending flags overrun.
module shr_frame_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    shr_frame_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] send_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   send_prev;
    logic                   clr_prev;
    logic [SYNC_STAGES:0]   arm;
    logic                   send_edge;
    logic                   clr_edge;
    logic                   pend_send;
    logic                   pend_clr;
    logic                   pend_auto;
    logic                   grant_clr;
    logic                   grant_send;
    logic                   grant_auto;
    logic                   any_grant;
    logic [CNT_W-1:0]       auto_timer;
    logic                   auto_run;
    logic                   auto_expire;
    logic                   wait_exit;
    logic [7:0]             gap_cnt;
    logic                   eng_start_q;
    logic                   busy_q;
    logic [1:0]             frame_src_q;
    logic [CNT_W-1:0]       frame_cnt_q;
    logic                   overrun_q;

    // Edges stay masked until the synchronizer has filled, so a level held through reset is not a request.
    assign send_edge = arm[SYNC_STAGES] & send_sync[SYNC_STAGES-1] & ~send_prev;
    assign clr_edge  = arm[SYNC_STAGES] & clr_sync[SYNC_STAGES-1] & ~clr_prev;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            send_sync <= '0;
            clr_sync  <= '0;
            send_prev <= 1'b0;
            clr_prev  <= 1'b0;
            arm       <= '0;
        end else begin
            send_sync <= {send_sync[SYNC_STAGES-2:0], bus.req_send};
            clr_sync  <= {clr_sync[SYNC_STAGES-2:0], bus.req_clr};
            send_prev <= send_sync[SYNC_STAGES-1];
            clr_prev  <= clr_sync[SYNC_STAGES-1];
            arm       <= {arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign any_grant  = (state == IDLE) & (pend_clr | pend_send | pend_auto);
    assign grant_clr  = (state == IDLE) & pend_clr;
    assign grant_send = (state == IDLE) & pend_send & ~pend_clr;
    assign grant_auto = (state == IDLE) & pend_auto & ~pend_clr & ~pend_send;

    assign auto_run    = bus.auto_en & (bus.auto_period != '0);
    assign auto_expire = auto_run & (auto_timer == bus.auto_period - CNT_W'(1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend_send  <= 1'b0;
            pend_clr   <= 1'b0;
            pend_auto  <= 1'b0;
            auto_timer <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (clr_edge) begin
                if (pend_clr && !grant_clr) overrun_q <= 1'b1;
                pend_clr <= 1'b1;
            end else if (grant_clr) begin
                pend_clr <= 1'b0;
            end

            if (send_edge) begin
                if (pend_send && !grant_send) overrun_q <= 1'b1;
                pend_send <= 1'b1;
            end else if (grant_send) begin
                pend_send <= 1'b0;
            end

            // An auto grant trails its own expiry reload by one cycle; reloading again would stretch the period.
            if (!auto_run) begin
                auto_timer <= '0;
                pend_auto  <= 1'b0;
            end else begin
                if (auto_expire) pend_auto <= 1'b1;
                else if (grant_auto) pend_auto <= 1'b0;
                if (auto_expire || grant_clr || grant_send) auto_timer <= '0;
                else auto_timer <= auto_timer + CNT_W'(1);
            end
        end
    end

`ifdef SHR_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wait_cnt;
    logic              wdog_fire;
    logic              wdog_err_q;

    assign wdog_fire = (state == WAIT) & (wait_cnt == WDOG_W'(TIMEOUT - 1));
    assign wait_exit = bus.eng_done | wdog_fire;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WDOG_W'(1);
            if (wdog_fire && !bus.eng_done) wdog_err_q <= 1'b1;
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT != 0);
    assign wait_exit      = bus.eng_done;
    assign bus.wdog_err   = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_src_q <= 2'b00;
            frame_cnt_q <= '0;
            gap_cnt     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        state       <= START;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        frame_src_q <= pend_clr ? {bus.clr_to_one, ~bus.clr_to_one} : 2'b00;
                    end
                end
                START: begin
                    eng_start_q <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_done) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                    if (wait_exit) begin
                        frame_src_q <= 2'b00;
                        if (bus.gap_cycles == 8'd0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= bus.gap_cycles;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= 8'd1) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.eng_start = eng_start_q;
    assign bus.busy      = busy_q;
    assign bus.frame_src = frame_src_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_shr_frame_scheduler.sv
// Self-checking bench for shr_frame_scheduler: vector table plus multi-cycle sequences, scoreboarded frame_src.
module tb_shr_frame_scheduler;
    localparam int CNT_W = 16;

    logic clk_in = 1'b0;
    logic rst_n;
    always #5 clk_in = ~clk_in;

    shr_frame_scheduler_if #(.CNT_W(CNT_W)) bus ();

    shr_frame_scheduler #(
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .TIMEOUT    (64)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         is_clr;
        bit         to_one;
        logic [1:0] exp_src;
        int         len;
        logic [7:0] gap;
    } vec_t;

    vec_t       vecs[4];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         starts = 0;
    int         done_delay = 40;
    int         eng_cnt = 0;
    int         done_cyc = 0;
    int         fall_cyc = 0;
    int         exp_frames = 0;
    logic       busy_d = 1'b0;
    logic [1:0] cur_exp = 2'b00;
    logic [1:0] exp_q[$];
    int         start_cyc[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse(input bit is_clr, output int rc);
        tick(1);
        if (is_clr) bus.req_clr = 1'b1;
        else bus.req_send = 1'b1;
        rc = cyc;
        tick(4);
        bus.req_clr  = 1'b0;
        bus.req_send = 1'b0;
        tick(4);
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (starts < n && i < budget) begin
            @(negedge clk_in);
            #1;
            i++;
        end
        check(name, (starts >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        i = 0;
        while (bus.busy && i < budget) begin
            @(negedge clk_in);
            #1;
            i++;
        end
        check(name, bus.busy, 0);
    endtask

    function automatic int last_start(input int back);
        return start_cyc[start_cyc.size() - 1 - back];
    endfunction

    // Monitor, scoreboard and shifter model: eng_done comes done_delay cycles after eng_start (0 = never).
    initial begin
        bus.eng_done = 1'b0;
        forever begin
            @(negedge clk_in);
            bus.eng_done = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        bus.eng_done = 1'b1;
                        done_cyc = cyc;
                        check("frame_src_in_wait", bus.frame_src, cur_exp);
                    end
                end
                if (bus.eng_start) begin
                    starts++;
                    start_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got eng_start=1 want 0 (cycle %0d)", cyc);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("frame_src_at_start", bus.frame_src, cur_exp);
                    end
                    eng_cnt = done_delay;
                end
            end
            if (busy_d && !bus.busy) fall_cyc = cyc;
            busy_d = bus.busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0;
        int rc;
        int ws;

        vecs[0] = '{1'b0, 1'b0, 2'b00, 40, 8'd3};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 5,  8'd0};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 7,  8'd2};
        vecs[3] = '{1'b0, 1'b1, 2'b00, 3,  8'd1};

        rst_n           = 1'b0;
        bus.req_send    = 1'b1;
        bus.req_clr     = 1'b0;
        bus.clr_to_one  = 1'b0;
        bus.auto_en     = 1'b0;
        bus.auto_period = '0;
        bus.gap_cycles  = 8'd3;

        // Reset with req_send already high: outputs quiet, and no start once released.
        tick(3);
        @(negedge clk_in);
        check("rst_eng_start", bus.eng_start, 0);
        check("rst_frame_src", bus.frame_src, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_wdog_err", bus.wdog_err, 0);
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check("no_start_after_release", starts, 0);
        bus.req_send = 1'b0;
        tick(5);

        for (int v = 0; v < 4; v++) begin
            s0 = starts;
            bus.gap_cycles = vecs[v].gap;
            bus.clr_to_one = vecs[v].to_one;
            done_delay     = vecs[v].len;
            exp_q.push_back(vecs[v].exp_src);
            exp_frames++;
            pulse(vecs[v].is_clr, rc);
            wait_starts(s0 + 1, 50, "vec_start");
            check("vec_latency", last_start(0) - rc, 4);
            wait_idle(200, "vec_idle");
            check("vec_frame_cnt", bus.frame_cnt, exp_frames);
            check("vec_busy_fall", fall_cyc - done_cyc, 32'(vecs[v].gap) + 1);
            check("vec_src_idle", bus.frame_src, 0);
        end

        // Clear and send edges together: clear first, send follows after done + gap.
        s0 = starts;
        bus.gap_cycles = 8'd3;
        bus.clr_to_one = 1'b1;
        done_delay     = 40;
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_frames += 2;
        tick(1);
        bus.req_clr  = 1'b1;
        bus.req_send = 1'b1;
        tick(4);
        bus.req_clr  = 1'b0;
        bus.req_send = 1'b0;
        wait_starts(s0 + 2, 200, "prio_starts");
        check("prio_spacing", last_start(0) - last_start(1), 45);
        wait_idle(200, "prio_idle");
        check("prio_frame_cnt", bus.frame_cnt, exp_frames);

        // Two send edges during one WAIT: overrun, and only one extra frame.
        check("overrun_before", bus.overrun, 0);
        s0 = starts;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_frames += 2;
        pulse(1'b0, rc);
        wait_starts(s0 + 1, 50, "ovr_first_start");
        pulse(1'b0, rc);
        pulse(1'b0, rc);
        check("overrun_set", bus.overrun, 1);
        wait_starts(s0 + 2, 200, "ovr_second_start");
        check("ovr_spacing", last_start(0) - last_start(1), 45);
        wait_idle(200, "ovr_idle");
        tick(100);
        check("ovr_no_third", starts, s0 + 2);
        check("ovr_frame_cnt", bus.frame_cnt, exp_frames);

        // Auto-repeat every 100 cycles, then auto_period=0 stops it.
        s0 = starts;
        done_delay = 10;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_frames += 3;
        bus.auto_period = 16'd100;
        bus.auto_en     = 1'b1;
        wait_starts(s0 + 3, 400, "auto_starts");
        bus.auto_period = '0;
        check("auto_spacing_1", last_start(1) - last_start(2), 100);
        check("auto_spacing_2", last_start(0) - last_start(1), 100);
        tick(300);
        check("auto_off_no_start", starts, s0 + 3);
        check("auto_frame_cnt", bus.frame_cnt, exp_frames);
        bus.auto_en = 1'b0;

        // Reset mid-frame aborts and nothing restarts.
        s0 = starts;
        done_delay = 40;
        exp_q.push_back(2'b00);
        pulse(1'b0, rc);
        wait_starts(s0 + 1, 50, "midrst_start");
        tick(5);
        rst_n = 1'b0;
        @(negedge clk_in);
        check("midrst_busy", bus.busy, 0);
        check("midrst_frame_cnt", bus.frame_cnt, 0);
        check("midrst_overrun", bus.overrun, 0);
        tick(1);
        rst_n = 1'b1;
        tick(60);
        check("midrst_no_restart", starts, s0 + 1);

`ifdef SHR_WDOG_EN
        // No eng_done: watchdog fires on the 64th WAIT cycle, frame not counted.
        s0 = starts;
        done_delay = 0;
        bus.gap_cycles = 8'd3;
        exp_q.push_back(2'b00);
        pulse(1'b0, rc);
        wait_starts(s0 + 1, 50, "wdog_start");
        ws = last_start(0);
        while (cyc < ws + 64 && cyc < ws + 200) @(negedge clk_in);
        #1;
        check("wdog_not_yet", bus.wdog_err, 0);
        @(negedge clk_in);
        #1;
        check("wdog_fired", bus.wdog_err, 1);
        check("wdog_busy_in_gap", bus.busy, 1);
        wait_idle(50, "wdog_idle");
        check("wdog_busy_fall", fall_cyc - ws, 68);
        check("wdog_frame_cnt", bus.frame_cnt, 0);
        check("wdog_sticky", bus.wdog_err, 1);
`else
        ws = 0;
        check("wdog_tied_low", bus.wdog_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
